sign_cost_cg_ctrl: RTL and testbench

Per-coefficient-group (CG) sequencer for the CABAC sign-bit cost path in the RDOQ rate estimator. It accepts the significance pattern of one CG, streamed in reverse scan order, and applies the sign-data-hiding (SDH) rule. It then drives an internal sign_bit_cost instance once per coded sign, accumulates the returned costs and hands the CG sign cost to the rate accumulator over a valid/ready handshake.

---
 rtl/cabac_rate_pkg.sv | 17 +
 rtl/sign_bit_cost.sv | 28 ++
 rtl/sign_cost_cg_ctrl.sv | 122 ++++++++++++
 tb/tb_sign_cost_cg_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cabac_rate_pkg.sv
// Shared types and default constants for the CABAC rate-estimation blocks.
package cabac_rate_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_EVAL,
        S_ISSUE,
        S_WAIT,
        S_OUTPUT
    } cg_state_e;

    localparam int          CG_SIZE_DEF       = 16;
    localparam int          SBH_THRESHOLD_DEF = 4;
    localparam logic [15:0] IEP_RATE_DEF      = 16'h8000;

endpackage

// File: rtl/sign_bit_cost.sv
// Cost of one equiprobable sign bin; done fires the cycle after a start rising edge.
module sign_bit_cost
    import cabac_rate_pkg::*;
#(
    parameter logic [15:0] IEP_RATE = IEP_RATE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        done,
    output logic [15:0] cost
);

    logic start_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            done    <= 1'b0;
        end else begin
            start_q <= start;
            done    <= start & ~start_q;
        end
    end

    assign cost = IEP_RATE;

endmodule

// File: rtl/sign_cost_cg_ctrl.sv
// Per-CG sign-cost sequencer: collects the significance map, applies sign hiding,
// prices each coded sign through sign_bit_cost and returns the CG total.
module sign_cost_cg_ctrl
    import cabac_rate_pkg::*;
#(
    parameter logic [15:0] IEP_RATE      = IEP_RATE_DEF,
    parameter int          CG_SIZE       = CG_SIZE_DEF,
    parameter int          SBH_THRESHOLD = SBH_THRESHOLD_DEF,
    parameter int          ACC_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cg_start,
    input  logic             sdh_en,
    input  logic             coef_valid,
    output logic             coef_ready,
    input  logic             coef_nz,
    input  logic             coef_last,
    output logic             cost_valid,
    input  logic             cost_ready,
    output logic [ACC_W-1:0] cost_out,
    output logic [4:0]       sign_count,
    output logic             sdh_applied,
    output logic             busy
);

    localparam int IDX_W = $clog2(CG_SIZE);
    localparam logic [IDX_W:0]   SBH_TH   = SBH_THRESHOLD[IDX_W:0];
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CG_SIZE - 1);

    cg_state_e         state, state_nx;
    logic              sdh_q;
    logic [IDX_W-1:0]  idx, first_nz, last_nz;
    logic [4:0]        nz_cnt, remaining, coded;
    logic [ACC_W-1:0]  acc, acc_nx;
    logic [IDX_W:0]    nz_span;
    logic              xfer, last_xfer, hide;
    logic              sbc_start, sbc_done;
    logic [15:0]       sbc_cost;

    assign coef_ready = (state == S_ACCEPT);
    assign cost_valid = (state == S_OUTPUT);
    assign busy       = (state != S_IDLE);
    assign sbc_start  = (state == S_ISSUE);

    assign xfer      = coef_valid & coef_ready;
    assign last_xfer = xfer & (coef_last | (idx == IDX_LAST));

    // Sign hiding only makes sense when at least two nonzeros are far enough apart.
    assign nz_span = {1'b0, last_nz} - {1'b0, first_nz};
    assign hide    = sdh_q && (nz_cnt >= 5'd2) && (nz_span >= SBH_TH);
    assign coded   = nz_cnt - {4'b0, hide};

    assign acc_nx = (state == S_WAIT && sbc_done)
                  ? acc + {{(ACC_W-16){1'b0}}, sbc_cost}
                  : acc;

    sign_bit_cost #(.IEP_RATE(IEP_RATE)) u_sbc (
        .clk   (clk),
        .rst_n (rst_n),
        .start (sbc_start),
        .done  (sbc_done),
        .cost  (sbc_cost)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (cg_start) state_nx = S_ACCEPT;
            S_ACCEPT: if (last_xfer) state_nx = S_EVAL;
            S_EVAL:   state_nx = (coded != 5'd0) ? S_ISSUE : S_OUTPUT;
            S_ISSUE:  state_nx = S_WAIT;
            S_WAIT:   if (sbc_done) state_nx = (remaining == 5'd1) ? S_OUTPUT : S_ISSUE;
            S_OUTPUT: if (cost_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sdh_q       <= 1'b0;
            nz_cnt      <= '0;
            remaining   <= '0;
            cost_out    <= '0;
            sign_count  <= '0;
            sdh_applied <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && cg_start) begin
                sdh_q  <= sdh_en;
                nz_cnt <= '0;
            end
            if (xfer && coef_nz) nz_cnt <= nz_cnt + 5'd1;
            if (state == S_EVAL) begin
                remaining   <= coded;
                sign_count  <= coded;
                sdh_applied <= hide;
            end
            if (state == S_WAIT && sbc_done) remaining <= remaining - 5'd1;
            if (state_nx == S_OUTPUT) cost_out <= acc_nx;
        end
    end

    // Datapath registers are always rewritten before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && cg_start) begin
            idx      <= '0;
            first_nz <= '0;
            last_nz  <= '0;
        end
        if (xfer) begin
            idx <= idx + 1'b1;
            if (coef_nz) begin
                last_nz <= idx;
                if (nz_cnt == 5'd0) first_nz <= idx;
            end
        end
        acc <= (state == S_IDLE) ? '0 : acc_nx;
    end

endmodule

// File: tb/tb_sign_cost_cg_ctrl.sv
// Directed bench for sign_cost_cg_ctrl: table of CG patterns plus handshake and reset sequences.
module tb_sign_cost_cg_ctrl;
    import cabac_rate_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cg_start = 1'b0, sdh_en = 1'b0;
    logic        coef_valid = 1'b0, coef_nz = 1'b0, coef_last = 1'b0;
    logic        cost_ready = 1'b0;
    logic        coef_ready, cost_valid, sdh_applied, busy;
    logic [31:0] cost_out;
    logic [4:0]  sign_count;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic start_d = 1'b0;

    always #5 clk = ~clk;

    sign_cost_cg_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cg_start(cg_start), .sdh_en(sdh_en),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_nz(coef_nz),
        .coef_last(coef_last), .cost_valid(cost_valid), .cost_ready(cost_ready),
        .cost_out(cost_out), .sign_count(sign_count), .sdh_applied(sdh_applied),
        .busy(busy)
    );

    // Running count of start rising edges seen by the cost unit.
    always @(posedge clk) begin
        if (dut.sbc_start && !start_d) pulses++;
        start_d <= dut.sbc_start;
    end

    typedef struct {
        logic        sdh;
        logic [15:0] pat;
        int          last;      // 16 = no explicit coef_last
        int          exp_cnt;
        logic        exp_sdh;
        int          exp_cost;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Opens a CG, streams the pattern and returns cycles until cost_valid.
    task automatic run_to_output(input vec_t v, output int lat, output int npulse);
        int p0;
        p0 = pulses;
        sdh_en   = v.sdh;
        cg_start = 1'b1;
        tick();
        cg_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            coef_valid = 1'b1;
            coef_nz    = v.pat[i];
            coef_last  = (i == v.last);
            tick();
            if (i == v.last) break;
        end
        coef_valid = 1'b0;
        coef_nz    = 1'b0;
        coef_last  = 1'b0;
        lat = 0;
        while (!cost_valid && lat < 100) begin
            tick();
            lat++;
        end
        npulse = pulses - p0;
    endtask

    task automatic release_result();
        cost_ready = 1'b1;
        tick();
        cost_ready = 1'b0;
    endtask

    initial begin
        int lat, np;
        vec_t v;

        vecs[0] = '{1'b1, 16'h0005,  3,  2, 1'b0,  65536,  5};
        vecs[1] = '{1'b1, 16'h004A,  6,  2, 1'b1,  65536,  5};
        vecs[2] = '{1'b1, 16'h0000,  3,  0, 1'b0,      0,  1};
        vecs[3] = '{1'b0, 16'hFFFF, 16, 16, 1'b0, 524288, 33};
        vecs[4] = '{1'b1, 16'h0020, 15,  1, 1'b0,  32768,  3};
        vecs[5] = '{1'b1, 16'h0044,  7,  1, 1'b1,  32768,  3};
        vecs[6] = '{1'b1, 16'h0024,  5,  2, 1'b0,  65536,  5};
        vecs[7] = '{1'b1, 16'hFFFF, 16, 15, 1'b1, 491520, 31};

        #12;
        check("reset_cost_valid", cost_valid, 0);
        check("reset_coef_ready", coef_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_cost_out", cost_out, 0);
        check("reset_sign_count", sign_count, 0);
        check("reset_sdh", sdh_applied, 0);
        rst_n = 1'b1;
        tick();

        // Coefficients offered while idle must not open or disturb a CG.
        coef_valid = 1'b1;
        coef_nz    = 1'b1;
        tick();
        tick();
        check("idle_coef_ignored_busy", busy, 0);
        check("idle_coef_ready", coef_ready, 0);
        coef_valid = 1'b0;
        coef_nz    = 1'b0;

        for (int k = 0; k < 8; k++) begin
            run_to_output(vecs[k], lat, np);
            check($sformatf("v%0d_latency", k), lat, vecs[k].exp_lat);
            check($sformatf("v%0d_cost", k), cost_out, vecs[k].exp_cost);
            check($sformatf("v%0d_count", k), sign_count, vecs[k].exp_cnt);
            check($sformatf("v%0d_sdh", k), sdh_applied, vecs[k].exp_sdh);
            check($sformatf("v%0d_pulses", k), np, vecs[k].exp_cnt);
            check($sformatf("v%0d_coef_ready", k), coef_ready, 0);
            release_result();
            check($sformatf("v%0d_idle", k), busy, 0);
            check($sformatf("v%0d_valid_drop", k), cost_valid, 0);
        end

        // Back-pressure: result held while cost_ready low, cg_start ignored.
        run_to_output(vecs[0], lat, np);
        for (int c = 0; c < 5; c++) begin
            cg_start = (c == 2);
            tick();
            check("hold_valid", cost_valid, 1);
            check("hold_cost", cost_out, 65536);
            check("hold_count", sign_count, 2);
            check("hold_coef_ready", coef_ready, 0);
        end
        cg_start = 1'b0;
        release_result();
        check("hold_idle", busy, 0);
        tick();
        check("hold_start_ignored", busy, 0);

        // Reset during WAIT of a 3-sign CG.
        v = '{1'b0, 16'h0007, 2, 3, 1'b0, 98304, 7};
        sdh_en   = 1'b0;
        cg_start = 1'b1;
        tick();
        cg_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            coef_valid = 1'b1;
            coef_nz    = 1'b1;
            coef_last  = (i == 2);
            tick();
        end
        coef_valid = 1'b0;
        coef_last  = 1'b0;
        coef_nz    = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_cost_valid", cost_valid, 0);
        check("rst_cost_out", cost_out, 0);
        check("rst_busy", busy, 0);
        check("rst_sign_count", sign_count, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_no_result", cost_valid, 0);
        run_to_output(v, lat, np);
        check("post_rst_latency", lat, v.exp_lat);
        check("post_rst_cost", cost_out, v.exp_cost);
        check("post_rst_count", sign_count, v.exp_cnt);
        check("post_rst_pulses", np, v.exp_cnt);
        release_result();
        check("post_rst_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
